mul_unit_param: RTL and testbench

MUL_UNIT_PARAM -- requirements
Module: mul_unit_param

---
 rtl/mul_unit_param.sv | 131 +++++++++++++
 tb/tb_mul_unit_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit_param.sv
// Iterative radix-2^BITS_PER_CYCLE multiplier supporting the RISC-V MUL/MULH/MULHSU/MULHU family.
// Operands are converted to magnitudes on accept; the sign is restored in a single FIXUP cycle.
module mul_unit_param #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 STALL_MUL,
   input  logic                 FLUSH,
   input  logic                 START,
   input  logic [1:0]           OP,
   input  logic [WIDTH-1:0]     MULTIPLIER,
   input  logic [WIDTH-1:0]     MULTIPLICAND,
   output logic [WIDTH-1:0]     RESULT,
   output logic [2*WIDTH-1:0]   PRODUCT_OUT,
   output logic                 VALID,
   output logic                 READY
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

   state_t             state, state_n;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [2*WIDTH-1:0] mcand, mcand_n;
   logic [WIDTH-1:0]   mplier, mplier_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic               negate, negate_n;
   logic               sel_hi, sel_hi_n;
   logic [WIDTH-1:0]   result_n;
   logic [2*WIDTH-1:0] product_n;
   logic               valid_n;

   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] digit, fixed;

   assign READY  = (state == IDLE) || (state == DONE);
   assign sign_a = ((OP == 2'b01) || (OP == 2'b10)) && MULTIPLIER[WIDTH-1];
   assign sign_b = (OP == 2'b01) && MULTIPLICAND[WIDTH-1];
   assign mag_a  = sign_a ? ('0 - MULTIPLIER) : MULTIPLIER;
   assign mag_b  = sign_b ? ('0 - MULTIPLICAND) : MULTIPLICAND;
   assign digit  = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
   assign fixed  = negate ? ('0 - acc) : acc;

   always_comb begin
      state_n   = state;
      acc_n     = acc;
      mcand_n   = mcand;
      mplier_n  = mplier;
      cnt_n     = cnt;
      negate_n  = negate;
      sel_hi_n  = sel_hi;
      result_n  = RESULT;
      product_n = PRODUCT_OUT;
      valid_n   = VALID;
      if (!STALL_MUL) begin
         if (FLUSH) begin
            state_n = IDLE;
            valid_n = 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (START) begin
                     mcand_n  = {{WIDTH{1'b0}}, mag_b};
                     mplier_n = mag_a;
                     negate_n = sign_a ^ sign_b;
                     sel_hi_n = (OP != 2'b00);
                     acc_n    = '0;
                     cnt_n    = CW'(N);
                     valid_n  = 1'b0;
                     state_n  = BUSY;
                  end
               end
               BUSY: begin
                  // Zero shortcut is only taken on the first iteration so latency stays data-independent otherwise.
                  if ((cnt == CW'(N)) && ((mcand == '0) || (mplier == '0))) begin
                     acc_n   = '0;
                     cnt_n   = '0;
                     state_n = FIXUP;
                  end else begin
                     acc_n    = acc + mcand * digit;
                     mcand_n  = mcand << BITS_PER_CYCLE;
                     mplier_n = mplier >> BITS_PER_CYCLE;
                     cnt_n    = cnt - CW'(1);
                     if (cnt == CW'(1))
                        state_n = FIXUP;
                  end
               end
               FIXUP: begin
                  product_n = fixed;
                  result_n  = sel_hi ? fixed[2*WIDTH-1:WIDTH] : fixed[WIDTH-1:0];
                  valid_n   = 1'b1;
                  state_n   = DONE;
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         cnt         <= '0;
         negate      <= 1'b0;
         sel_hi      <= 1'b0;
         RESULT      <= '0;
         PRODUCT_OUT <= '0;
         VALID       <= 1'b0;
      end else begin
         state       <= state_n;
         acc         <= acc_n;
         mcand       <= mcand_n;
         mplier      <= mplier_n;
         cnt         <= cnt_n;
         negate      <= negate_n;
         sel_hi      <= sel_hi_n;
         RESULT      <= result_n;
         PRODUCT_OUT <= product_n;
         VALID       <= valid_n;
      end
   end

endmodule

// File: tb/tb_mul_unit_param.sv
// Self-checking bench for mul_unit_param: directed cases on the 32/4 configuration plus
// randomized comparison of several configurations against a wide-integer reference model.
module tb_mul_unit_param;

   logic        CLK = 1'b0;
   logic        RST_N, STALL_MUL, FLUSH, START;
   logic [1:0]  OP;
   logic [63:0] A, B;

   logic [31:0]  r32 [3];
   logic [63:0]  p32 [3];
   logic         v32 [3];
   logic         rd32 [3];
   logic [63:0]  r64;
   logic [127:0] p64;
   logic         v64, rd64;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mul_unit_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .STALL_MUL(STALL_MUL), .FLUSH(FLUSH), .START(START), .OP(OP),
      .MULTIPLIER(A[31:0]), .MULTIPLICAND(B[31:0]), .RESULT(r32[0]), .PRODUCT_OUT(p32[0]),
      .VALID(v32[0]), .READY(rd32[0]));

   mul_unit_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_bpc1 (
      .CLK(CLK), .RST_N(RST_N), .STALL_MUL(STALL_MUL), .FLUSH(FLUSH), .START(START), .OP(OP),
      .MULTIPLIER(A[31:0]), .MULTIPLICAND(B[31:0]), .RESULT(r32[1]), .PRODUCT_OUT(p32[1]),
      .VALID(v32[1]), .READY(rd32[1]));

   mul_unit_param #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_bpc2 (
      .CLK(CLK), .RST_N(RST_N), .STALL_MUL(STALL_MUL), .FLUSH(FLUSH), .START(START), .OP(OP),
      .MULTIPLIER(A[31:0]), .MULTIPLICAND(B[31:0]), .RESULT(r32[2]), .PRODUCT_OUT(p32[2]),
      .VALID(v32[2]), .READY(rd32[2]));

   mul_unit_param #(.WIDTH(64), .BITS_PER_CYCLE(8)) u_w64 (
      .CLK(CLK), .RST_N(RST_N), .STALL_MUL(STALL_MUL), .FLUSH(FLUSH), .START(START), .OP(OP),
      .MULTIPLIER(A), .MULTIPLICAND(B), .RESULT(r64), .PRODUCT_OUT(p64),
      .VALID(v64), .READY(rd64));

   // Reference: sign/zero-extend to 128 bits per the op's signedness and multiply.
   function automatic logic [127:0] ref_prod(input int w, input logic [1:0] op,
                                             input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ea, eb, p;
      logic sa, sb;
      sa = (op == 2'd1) || (op == 2'd2);
      sb = (op == 2'd1);
      if (w == 32) begin
         ea = {{96{sa & a[31]}}, a[31:0]};
         eb = {{96{sb & b[31]}}, b[31:0]};
      end else begin
         ea = {{64{sa & a[63]}}, a};
         eb = {{64{sb & b[63]}}, b};
      end
      p = ea * eb;
      if (w == 32) p[127:64] = '0;
      return p;
   endfunction

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 64'h0;
         1: return 64'h0000_0000_8000_0000;
         2: return 64'h8000_0000_0000_0000;
         3: return '1;
         4: return 64'($urandom_range(0, 15));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      OP = op; A = a; B = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (v32[0] !== 1'b1 && lat < 100) begin
         @(posedge CLK); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; STALL_MUL = 1'b0; FLUSH = 1'b0; START = 1'b0; OP = 2'd0; A = '0; B = '0;
      repeat (2) @(posedge CLK);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (v32[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, v32[k]); end
         checks++; if (r32[k] !== 32'h0) begin errors++; $display("FAIL reset_result[%0d]: got %h expected 0", k, r32[k]); end
         checks++; if (p32[k] !== 64'h0) begin errors++; $display("FAIL reset_product[%0d]: got %h expected 0", k, p32[k]); end
      end
      checks++; if (v64 !== 1'b0 || p64 !== '0) begin errors++; $display("FAIL reset_w64: got valid %b prod %h expected 0", v64, p64); end
      RST_N = 1'b1;
      @(posedge CLK); #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (rd32[k] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 1", k, rd32[k]); end
      end
      checks++; if (rd64 !== 1'b1) begin errors++; $display("FAIL reset_ready_w64: got %b expected 1", rd64); end
   endtask

   task automatic test_directed();
      int lat;
      issue(2'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_valid(lat);
      checks++; if (lat != 9) begin errors++; $display("FAIL mulhu_latency: got %0d expected 9", lat); end
      checks++; if (p32[0] !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mulhu_product: got %h expected fffffffe00000001", p32[0]); end
      checks++; if (r32[0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result: got %h expected fffffffe", r32[0]); end
      checks++; if (rd32[0] !== 1'b1) begin errors++; $display("FAIL done_ready: got %b expected 1", rd32[0]); end

      issue(2'd1, 64'h8000_0000, 64'h8000_0000);
      wait_valid(lat);
      checks++; if (r32[0] !== 32'h4000_0000) begin errors++; $display("FAIL mulh_minneg: got %h expected 40000000", r32[0]); end
      checks++; if (p32[0] !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mulh_minneg_prod: got %h expected 4000000000000000", p32[0]); end

      issue(2'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_valid(lat);
      checks++; if (r32[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result: got %h expected ffffffff", r32[0]); end
      checks++; if (p32[0] !== 64'hFFFF_FFFF_0000_0001) begin errors++; $display("FAIL mulhsu_product: got %h expected ffffffff00000001", p32[0]); end

      issue(2'd0, 64'h0, 64'h1234_5678);
      wait_valid(lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", lat); end
      checks++; if (r32[0] !== 32'h0) begin errors++; $display("FAIL zero_result: got %h expected 0", r32[0]); end
   endtask

   task automatic test_stall();
      int lat;
      issue(2'd0, 64'h7, 64'hFFFF_FFFD);
      repeat (3) begin @(posedge CLK); #1; end
      STALL_MUL = 1'b1; FLUSH = 1'b1; START = 1'b1;
      repeat (5) begin @(posedge CLK); #1; end
      checks++; if (v32[0] !== 1'b0 || rd32[0] !== 1'b0) begin errors++; $display("FAIL stall_frozen: got valid %b ready %b expected 0 0", v32[0], rd32[0]); end
      STALL_MUL = 1'b0; FLUSH = 1'b0; START = 1'b0;
      wait_valid(lat);
      lat = lat + 8;
      checks++; if (lat != 14) begin errors++; $display("FAIL stall_latency: got %0d expected 14", lat); end
      checks++; if (r32[0] !== 32'hFFFF_FFEB) begin errors++; $display("FAIL stall_result: got %h expected ffffffeb", r32[0]); end
      checks++; if (p32[0] !== 64'h0000_0006_FFFF_FFEB) begin errors++; $display("FAIL stall_product: got %h expected 00000006ffffffeb", p32[0]); end
   endtask

   task automatic test_flush();
      int seen = 0;
      issue(2'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      repeat (3) begin @(posedge CLK); #1; end
      FLUSH = 1'b1; START = 1'b1; OP = 2'd0; A = 64'd5; B = 64'd5;
      @(posedge CLK); #1;
      FLUSH = 1'b0; START = 1'b0;
      checks++; if (rd32[0] !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", rd32[0]); end
      checks++; if (v32[0] !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", v32[0]); end
      checks++; if (r32[0] !== 32'hFFFF_FFEB) begin errors++; $display("FAIL flush_result_kept: got %h expected ffffffeb", r32[0]); end
      checks++; if (p32[0] !== 64'h0000_0006_FFFF_FFEB) begin errors++; $display("FAIL flush_product_kept: got %h expected 00000006ffffffeb", p32[0]); end
      repeat (12) begin @(posedge CLK); #1; if (v32[0] === 1'b1) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      issue(2'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      repeat (3) begin @(posedge CLK); #1; end
      #2 RST_N = 1'b0;
      #1;
      checks++; if (v32[0] !== 1'b0 || r32[0] !== 32'h0 || p32[0] !== 64'h0) begin
         errors++; $display("FAIL async_reset: got valid %b result %h product %h expected all 0", v32[0], r32[0], p32[0]);
      end
      checks++; if (rd32[0] !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", rd32[0]); end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      repeat (12) begin @(posedge CLK); #1; if (v32[0] === 1'b1) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL reset_abort: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(2'd0, 64'd10, 64'd20);
      wait_valid(lat);
      checks++; if (r32[0] !== 32'd200) begin errors++; $display("FAIL b2b_first: got %0d expected 200", r32[0]); end
      issue(2'd0, 64'd3, 64'd5);
      checks++; if (v32[0] !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", v32[0]); end
      wait_valid(lat);
      checks++; if (lat != 9) begin errors++; $display("FAIL b2b_latency: got %0d expected 9", lat); end
      checks++; if (r32[0] !== 32'd15) begin errors++; $display("FAIL b2b_result: got %0d expected 15", r32[0]); end
   endtask

   task automatic test_random(input int iters);
      int bpc [3] = '{4, 1, 2};
      int lat [4];
      int cyc, exp_lat;
      logic [1:0] op;
      logic [63:0] a, b;
      logic [127:0] p;
      logic zero32, zero64;
      FLUSH = 1'b1;
      @(posedge CLK); #1;
      FLUSH = 1'b0;
      for (int it = 0; it < iters; it++) begin
         op = 2'($urandom_range(0, 3));
         a = pick_operand();
         b = pick_operand();
         issue(op, a, b);
         lat = '{-1, -1, -1, -1};
         cyc = 0;
         while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0) && cyc < 80) begin
            @(posedge CLK); #1;
            cyc++;
            for (int k = 0; k < 3; k++) if (v32[k] === 1'b1 && lat[k] < 0) lat[k] = cyc;
            if (v64 === 1'b1 && lat[3] < 0) lat[3] = cyc;
         end
         zero32 = (a[31:0] == 32'h0) || (b[31:0] == 32'h0);
         zero64 = (a == 64'h0) || (b == 64'h0);
         p = ref_prod(32, op, a, b);
         for (int k = 0; k < 3; k++) begin
            exp_lat = zero32 ? 2 : 32 / bpc[k] + 1;
            checks++; if (lat[k] != exp_lat) begin errors++; $display("FAIL rnd_latency[bpc%0d] op%0d %h*%h: got %0d expected %0d", bpc[k], op, a[31:0], b[31:0], lat[k], exp_lat); end
            checks++; if (p32[k] !== p[63:0]) begin errors++; $display("FAIL rnd_product[bpc%0d] op%0d %h*%h: got %h expected %h", bpc[k], op, a[31:0], b[31:0], p32[k], p[63:0]); end
            checks++; if (r32[k] !== ((op == 2'd0) ? p[31:0] : p[63:32])) begin
               errors++; $display("FAIL rnd_result[bpc%0d] op%0d %h*%h: got %h expected %h", bpc[k], op, a[31:0], b[31:0], r32[k], (op == 2'd0) ? p[31:0] : p[63:32]);
            end
         end
         p = ref_prod(64, op, a, b);
         exp_lat = zero64 ? 2 : 9;
         checks++; if (lat[3] != exp_lat) begin errors++; $display("FAIL rnd_latency_w64 op%0d %h*%h: got %0d expected %0d", op, a, b, lat[3], exp_lat); end
         checks++; if (p64 !== p) begin errors++; $display("FAIL rnd_product_w64 op%0d %h*%h: got %h expected %h", op, a, b, p64, p); end
         checks++; if (r64 !== ((op == 2'd0) ? p[63:0] : p[127:64])) begin
            errors++; $display("FAIL rnd_result_w64 op%0d %h*%h: got %h expected %h", op, a, b, r64, (op == 2'd0) ? p[63:0] : p[127:64]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random(150);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
